fft_spectrum_sink: RTL

Consumes the natural-order result stream of the 1024-point pipelined FFT (AXI4-Stream master side with no backpressure), checks frame framing, computes per-bin power re²+im², and stores it in an internal ping-pong spectrum buffer. A downstream reader (display or peak search) reads the most recent complete spectrum through a simple random-access port while the next frame is being written. The block sits directly on the FFT output stream.

---
 rtl/fft_spectrum_sink.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/fft_spectrum_sink.sv
// fft_spectrum_sink
// Receives the natural-order 1024-point FFT result stream, checks frame
// framing, computes per-bin power re^2 + im^2 and stores it in a ping-pong
// spectrum buffer. A reader sees the most recent complete spectrum through
// a one-cycle-latency random-access port while the next frame is written.
module fft_spectrum_sink #(
    parameter int LOGS_FFT_LEN = 10,
    parameter int DATA_WIDTH   = 16,
    parameter int USER_WIDTH   = 24,
    parameter int POW_WIDTH    = 2 * DATA_WIDTH
) (
    input  logic                      i_aclk,
    input  logic                      i_aresetn,
    input  logic                      i_axi4s_data_tvalid,
    input  logic [2*DATA_WIDTH-1:0]   i_axi4s_data_tdata,
    input  logic                      i_axi4s_data_tlast,
    input  logic [USER_WIDTH-1:0]     i_axi4s_data_tuser,
    input  logic [LOGS_FFT_LEN-1:0]   i_rd_addr,
    output logic [POW_WIDTH-1:0]      o_rd_data,
    output logic [4:0]                o_blk_exp,
    output logic                      o_frame_valid,
    output logic                      o_frame_done,
    output logic [15:0]               o_frame_cnt,
    output logic [7:0]                o_err_cnt
);

    localparam int FFT_LEN = 1 << LOGS_FFT_LEN;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RECV    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    localparam logic [LOGS_FFT_LEN-1:0] LAST_IDX = '1;

    // Framing state
    logic [1:0]                  state;
    logic [1:0]                  nxt_state;
    logic [LOGS_FFT_LEN-1:0]     cnt;
    logic [LOGS_FFT_LEN-1:0]     nxt_cnt;
    logic                        wr_bank;
    logic [4:0]                  cur_exp;

    // Decoded current beat
    logic [LOGS_FFT_LEN-1:0]     beat_idx;
    logic [4:0]                  beat_exp;
    logic signed [DATA_WIDTH-1:0] beat_re;
    logic signed [DATA_WIDTH-1:0] beat_im;
    logic                        beat_wr;
    logic                        beat_err;
    logic                        beat_good;
    logic                        beat_start;
    logic                        unused_user;

    // Power pipeline
    logic                        s1_vld;
    logic                        s1_good;
    logic                        s1_bank;
    logic [LOGS_FFT_LEN-1:0]     s1_addr;
    logic [4:0]                  s1_exp;
    logic signed [DATA_WIDTH-1:0] s1_re;
    logic signed [DATA_WIDTH-1:0] s1_im;

    logic signed [2*DATA_WIDTH-1:0] re_prod;
    logic signed [2*DATA_WIDTH-1:0] im_prod;

    logic                        s2_vld;
    logic                        s2_good;
    logic                        s2_bank;
    logic [LOGS_FFT_LEN-1:0]     s2_addr;
    logic [4:0]                  s2_exp;
    logic [POW_WIDTH-1:0]        s2_re_sq;
    logic [POW_WIDTH-1:0]        s2_im_sq;

    logic                        s3_vld;
    logic                        s3_good;
    logic                        s3_bank;
    logic [LOGS_FFT_LEN-1:0]     s3_addr;
    logic [4:0]                  s3_exp;
    logic [POW_WIDTH-1:0]        s3_pow;

    logic                        s4_good;
    logic                        s4_bank;
    logic [4:0]                  s4_exp;

    logic                        rd_bank;

    // Two banks of FFT_LEN bins, addressed as {bank, bin}
    logic [POW_WIDTH-1:0]        spec_mem [0:2*FFT_LEN-1];

    assign beat_idx = i_axi4s_data_tuser[8 +: LOGS_FFT_LEN];
    assign beat_exp = i_axi4s_data_tuser[4:0];
    assign beat_re  = i_axi4s_data_tdata[DATA_WIDTH-1:0];
    assign beat_im  = i_axi4s_data_tdata[2*DATA_WIDTH-1:DATA_WIDTH];
    assign unused_user = ^{i_axi4s_data_tuser[7:5],
                           i_axi4s_data_tuser[USER_WIDTH-1:8+LOGS_FFT_LEN]};

    // Framing decode: classify the current beat and pick the next state
    always_comb begin
        nxt_state  = state;
        nxt_cnt    = cnt;
        beat_wr    = 1'b0;
        beat_err   = 1'b0;
        beat_good  = 1'b0;
        beat_start = 1'b0;
        if (i_axi4s_data_tvalid) begin
            case (state)
                ST_IDLE: begin
                    if (beat_idx == '0) begin
                        if (i_axi4s_data_tlast) begin
                            beat_err = 1'b1;
                        end else begin
                            beat_start = 1'b1;
                            beat_wr    = 1'b1;
                            nxt_state  = ST_RECV;
                            nxt_cnt    = {{(LOGS_FFT_LEN-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        beat_err  = 1'b1;
                        nxt_state = i_axi4s_data_tlast ? ST_IDLE : ST_DISCARD;
                    end
                end
                ST_RECV: begin
                    if (beat_idx == cnt) begin
                        if (cnt == LAST_IDX) begin
                            nxt_cnt = '0;
                            if (i_axi4s_data_tlast) begin
                                beat_wr   = 1'b1;
                                beat_good = 1'b1;
                                nxt_state = ST_IDLE;
                            end else begin
                                beat_err  = 1'b1;
                                nxt_state = ST_DISCARD;
                            end
                        end else if (i_axi4s_data_tlast) begin
                            beat_err  = 1'b1;
                            nxt_state = ST_IDLE;
                            nxt_cnt   = '0;
                        end else begin
                            beat_wr = 1'b1;
                            nxt_cnt = cnt + 1'b1;
                        end
                    end else begin
                        beat_err  = 1'b1;
                        nxt_cnt   = '0;
                        nxt_state = i_axi4s_data_tlast ? ST_IDLE : ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (i_axi4s_data_tlast) begin
                        nxt_state = ST_IDLE;
                    end
                end
                default: begin
                    nxt_state = ST_IDLE;
                    nxt_cnt   = '0;
                end
            endcase
        end
    end

    // Framing state, write-bank selection, frame exponent and error counter
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            wr_bank   <= 1'b1;
            cur_exp   <= '0;
            o_err_cnt <= '0;
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
            if (beat_start) begin
                cur_exp <= beat_exp;
            end
            // The write bank flips as soon as the final beat is accepted so a
            // back-to-back frame lands in the other bank while this one drains.
            if (beat_good) begin
                wr_bank <= ~wr_bank;
            end
            if (beat_err && (o_err_cnt != 8'hFF)) begin
                o_err_cnt <= o_err_cnt + 8'd1;
            end
        end
    end

    // Squared terms, computed at full signed width
    always_comb begin
        re_prod = s1_re * s1_re;
        im_prod = s1_im * s1_im;
    end

    // Power pipeline: capture, square, sum; bank and frame-good ride along
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            s1_vld   <= 1'b0;
            s1_good  <= 1'b0;
            s1_bank  <= 1'b0;
            s1_addr  <= '0;
            s1_exp   <= '0;
            s1_re    <= '0;
            s1_im    <= '0;
            s2_vld   <= 1'b0;
            s2_good  <= 1'b0;
            s2_bank  <= 1'b0;
            s2_addr  <= '0;
            s2_exp   <= '0;
            s2_re_sq <= '0;
            s2_im_sq <= '0;
            s3_vld   <= 1'b0;
            s3_good  <= 1'b0;
            s3_bank  <= 1'b0;
            s3_addr  <= '0;
            s3_exp   <= '0;
            s3_pow   <= '0;
            s4_good  <= 1'b0;
            s4_bank  <= 1'b0;
            s4_exp   <= '0;
        end else begin
            s1_vld   <= beat_wr;
            s1_good  <= beat_good;
            s1_bank  <= wr_bank;
            s1_addr  <= beat_idx;
            s1_exp   <= cur_exp;
            s1_re    <= beat_re;
            s1_im    <= beat_im;

            s2_vld   <= s1_vld;
            s2_good  <= s1_good;
            s2_bank  <= s1_bank;
            s2_addr  <= s1_addr;
            s2_exp   <= s1_exp;
            s2_re_sq <= POW_WIDTH'($unsigned(re_prod));
            s2_im_sq <= POW_WIDTH'($unsigned(im_prod));

            s3_vld   <= s2_vld;
            s3_good  <= s2_good;
            s3_bank  <= s2_bank;
            s3_addr  <= s2_addr;
            s3_exp   <= s2_exp;
            s3_pow   <= s2_re_sq + s2_im_sq;

            s4_good  <= s3_vld & s3_good;
            s4_bank  <= s3_bank;
            s4_exp   <= s3_exp;
        end
    end

    // Spectrum RAM write port (contents are not reset)
    always_ff @(posedge i_aclk) begin
        if (s3_vld) begin
            spec_mem[{s3_bank, s3_addr}] <= s3_pow;
        end
    end

    // Read port, bank swap and frame status once the final write has landed
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            rd_bank       <= 1'b0;
            o_rd_data     <= '0;
            o_blk_exp     <= '0;
            o_frame_valid <= 1'b0;
            o_frame_done  <= 1'b0;
            o_frame_cnt   <= '0;
        end else begin
            o_rd_data    <= spec_mem[{rd_bank, i_rd_addr}];
            o_frame_done <= s4_good;
            if (s4_good) begin
                rd_bank       <= s4_bank;
                o_blk_exp     <= s4_exp;
                o_frame_valid <= 1'b1;
                o_frame_cnt   <= o_frame_cnt + 16'd1;
            end
        end
    end

endmodule
